// File: rtl/ibex_tlul_host_mo.sv
// ibex_tlul_host_mo
//   Bridges an Ibex req/gnt port onto a TL-UL host port with up to
//   MaxOutstanding transactions in flight. Each accepted request occupies one
//   slot of a ring; the slot index is sent as a_source. Responses may come back
//   in any order on d_source, and are handed back to Ibex strictly in issue order.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i/we_i/be_i    Ibex request, write enable, byte enables
//   addr_i/wdata_i     Ibex byte address and write data
//   gnt_o              request accepted this cycle
//   rvalid_o           one-cycle response pulse, issue order
//   rdata_o/err_o      response data / error (hold between pulses)
//   tl_a_*_o           TL-UL A channel (flattened tl_h2d_t), tl_d_ready_o
//   tl_a_ready_i       TL-UL A channel ready
//   tl_d_*_i           TL-UL D channel (flattened tl_d2h_t)
//   outstanding_o      allocated, not-yet-retired slots
//   unexp_rsp_o        sticky flag: D beat on a free/completed/out-of-range source
module ibex_tlul_host_mo #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          ReadOnly       = 1'b0,
  parameter bit          PartialWrOp    = 1'b1,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  output logic [31:0]     rdata_o,
  output logic            err_o,
  output logic            tl_a_valid_o,
  output logic [2:0]      tl_a_opcode_o,
  output logic [2:0]      tl_a_param_o,
  output logic [1:0]      tl_a_size_o,
  output logic [7:0]      tl_a_source_o,
  output logic [31:0]     tl_a_address_o,
  output logic [3:0]      tl_a_mask_o,
  output logic [31:0]     tl_a_data_o,
  output logic            tl_d_ready_o,
  input  logic            tl_a_ready_i,
  input  logic            tl_d_valid_i,
  input  logic [7:0]      tl_d_source_i,
  input  logic [31:0]     tl_d_data_i,
  input  logic            tl_d_error_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            unexp_rsp_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [2:0] OpGet            = 3'd4;
  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;

  logic [PtrW-1:0]           wr_ptr, rd_ptr;
  logic [CntW-1:0]           count;
  logic [MaxOutstanding-1:0] pend_q, done_q, err_q;
  logic [31:0]               slot_rdata_q [MaxOutstanding];

  logic            full, ro_wr, bus_grant, local_grant;
  logic            d_in_range, d_hit, rd_done, rd_hit, retire;
  logic [PtrW-1:0] d_idx;
  logic [31:0]     retire_data;
  logic            retire_err;
  logic            unused_addr;

  // Word-aligned bus addresses make the low address bits irrelevant.
  assign unused_addr = ^addr_i[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign full        = (count == CntW'(MaxOutstanding));
  assign ro_wr       = ReadOnly & we_i;
  assign bus_grant   = tl_a_valid_o & tl_a_ready_i;
  // Writes on a read-only port take a slot but never touch the bus.
  assign local_grant = req_i & ~full & ro_wr;
  assign gnt_o       = bus_grant | local_grant;

  assign tl_a_valid_o   = req_i & ~full & ~ro_wr;
  assign tl_a_opcode_o  = !we_i ? OpGet :
                          ((be_i == 4'hF) || !PartialWrOp) ? OpPutFullData : OpPutPartialData;
  assign tl_a_param_o   = 3'd0;
  assign tl_a_size_o    = 2'd2;
  assign tl_a_source_o  = {{(8 - PtrW){1'b0}}, wr_ptr};
  assign tl_a_address_o = {addr_i[31:2], 2'b00};
  assign tl_a_mask_o    = we_i ? be_i : 4'hF;
  assign tl_a_data_o    = we_i ? wdata_i : 32'h0;
  assign tl_d_ready_o   = 1'b1;

  // Only a beat for a pending slot is accepted; the range check guards the
  // slot lookup for sources beyond the ring.
  assign d_in_range = (tl_d_source_i < 8'(MaxOutstanding));
  assign d_idx      = tl_d_source_i[PtrW-1:0];
  assign d_hit      = tl_d_valid_i & d_in_range & pend_q[d_idx];

  // The oldest slot retires either from stored contents or directly from a
  // beat arriving for it this cycle, giving one cycle of D-to-rvalid latency.
  assign rd_done     = done_q[rd_ptr];
  assign rd_hit      = d_hit & (d_idx == rd_ptr);
  assign retire      = rd_done | rd_hit;
  assign retire_data = rd_hit ? tl_d_data_i  : slot_rdata_q[rd_ptr];
  assign retire_err  = rd_hit ? tl_d_error_i : err_q[rd_ptr];

  assign outstanding_o = count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (gnt_o) wr_ptr <= ptr_inc(wr_ptr);
      if (retire) rd_ptr <= ptr_inc(rd_ptr);
      if (gnt_o && !retire) count <= count + CntW'(1);
      else if (!gnt_o && retire) count <= count - CntW'(1);
    end
  end

  // Per-slot state. Grant needs a free slot, a D hit a pending one and a
  // stored retire a done one, so at most one branch applies per slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      done_q <= '0;
      err_q  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) slot_rdata_q[i] <= '0;
    end else begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        if (gnt_o && (wr_ptr == PtrW'(i))) begin
          if (local_grant) begin
            done_q[i]       <= 1'b1;
            err_q[i]        <= 1'b1;
            slot_rdata_q[i] <= '0;
          end else begin
            pend_q[i] <= 1'b1;
          end
        end else if (d_hit && (d_idx == PtrW'(i))) begin
          pend_q[i] <= 1'b0;
          if (d_idx != rd_ptr) begin
            done_q[i]       <= 1'b1;
            err_q[i]        <= tl_d_error_i;
            slot_rdata_q[i] <= tl_d_data_i;
          end
        end else if (rd_done && (rd_ptr == PtrW'(i))) begin
          done_q[i] <= 1'b0;
        end
      end
    end
  end

  // Response outputs; data and error hold between pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      unexp_rsp_o <= 1'b0;
    end else begin
      rvalid_o <= retire;
      if (retire) begin
        rdata_o <= retire_data;
        err_o   <= retire_err;
      end
      if (tl_d_valid_i && !d_hit) unexp_rsp_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_tlul_host_mo.sv
// tb_ibex_tlul_host_mo
//   Directed bench for ibex_tlul_host_mo. Three instances share one stimulus
//   set: a (MaxOutstanding=4), b (MaxOutstanding=2, ReadOnly) and c
//   (MaxOutstanding=1). Each group of steps resets all of them and then checks
//   only the instance it targets.
module tb_ibex_tlul_host_mo;

  logic        clk, rst_n;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        a_ready, d_valid, d_error;
  logic [7:0]  d_source;
  logic [31:0] d_data;

  logic        a_gnt, a_rvalid, a_err, a_unexp, a_tl_a_valid, a_tl_d_ready;
  logic [31:0] a_rdata, a_tl_a_address, a_tl_a_data;
  logic [2:0]  a_tl_a_opcode, a_tl_a_param;
  logic [1:0]  a_tl_a_size;
  logic [7:0]  a_tl_a_source;
  logic [3:0]  a_tl_a_mask;
  logic [2:0]  a_outstanding;

  logic        b_gnt, b_rvalid, b_err, b_unexp, b_tl_a_valid, b_tl_d_ready;
  logic [31:0] b_rdata, b_tl_a_address, b_tl_a_data;
  logic [2:0]  b_tl_a_opcode, b_tl_a_param;
  logic [1:0]  b_tl_a_size;
  logic [7:0]  b_tl_a_source;
  logic [3:0]  b_tl_a_mask;
  logic [1:0]  b_outstanding;

  logic        c_gnt, c_rvalid, c_err, c_unexp, c_tl_a_valid, c_tl_d_ready;
  logic [31:0] c_rdata, c_tl_a_address, c_tl_a_data;
  logic [2:0]  c_tl_a_opcode, c_tl_a_param;
  logic [1:0]  c_tl_a_size;
  logic [7:0]  c_tl_a_source;
  logic [3:0]  c_tl_a_mask;
  logic [0:0]  c_outstanding;

  int vectors     = 0;
  int miscompares = 0;
  bit found;

  ibex_tlul_host_mo #(.MaxOutstanding(4), .ReadOnly(1'b0), .PartialWrOp(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
    .tl_a_valid_o(a_tl_a_valid), .tl_a_opcode_o(a_tl_a_opcode), .tl_a_param_o(a_tl_a_param),
    .tl_a_size_o(a_tl_a_size), .tl_a_source_o(a_tl_a_source), .tl_a_address_o(a_tl_a_address),
    .tl_a_mask_o(a_tl_a_mask), .tl_a_data_o(a_tl_a_data), .tl_d_ready_o(a_tl_d_ready),
    .tl_a_ready_i(a_ready), .tl_d_valid_i(d_valid), .tl_d_source_i(d_source),
    .tl_d_data_i(d_data), .tl_d_error_i(d_error), .outstanding_o(a_outstanding),
    .unexp_rsp_o(a_unexp)
  );

  ibex_tlul_host_mo #(.MaxOutstanding(2), .ReadOnly(1'b1), .PartialWrOp(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
    .tl_a_valid_o(b_tl_a_valid), .tl_a_opcode_o(b_tl_a_opcode), .tl_a_param_o(b_tl_a_param),
    .tl_a_size_o(b_tl_a_size), .tl_a_source_o(b_tl_a_source), .tl_a_address_o(b_tl_a_address),
    .tl_a_mask_o(b_tl_a_mask), .tl_a_data_o(b_tl_a_data), .tl_d_ready_o(b_tl_d_ready),
    .tl_a_ready_i(a_ready), .tl_d_valid_i(d_valid), .tl_d_source_i(d_source),
    .tl_d_data_i(d_data), .tl_d_error_i(d_error), .outstanding_o(b_outstanding),
    .unexp_rsp_o(b_unexp)
  );

  ibex_tlul_host_mo #(.MaxOutstanding(1), .ReadOnly(1'b0), .PartialWrOp(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(c_gnt), .rvalid_o(c_rvalid), .rdata_o(c_rdata), .err_o(c_err),
    .tl_a_valid_o(c_tl_a_valid), .tl_a_opcode_o(c_tl_a_opcode), .tl_a_param_o(c_tl_a_param),
    .tl_a_size_o(c_tl_a_size), .tl_a_source_o(c_tl_a_source), .tl_a_address_o(c_tl_a_address),
    .tl_a_mask_o(c_tl_a_mask), .tl_a_data_o(c_tl_a_data), .tl_d_ready_o(c_tl_d_ready),
    .tl_a_ready_i(a_ready), .tl_d_valid_i(d_valid), .tl_d_source_i(d_source),
    .tl_d_data_i(d_data), .tl_d_error_i(d_error), .outstanding_o(c_outstanding),
    .unexp_rsp_o(c_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [3:0] b,
                               input logic [31:0] ad, input logic [31:0] wd);
    req   = r;
    we    = w;
    be    = b;
    addr  = ad;
    wdata = wd;
  endtask

  task automatic drive_d(input logic v, input logic [7:0] src, input logic [31:0] dat,
                         input logic e);
    d_valid  = v;
    d_source = src;
    d_data   = dat;
    d_error  = e;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_clock();
    rst_n = 1'b1;
    step_clock();
  endtask

  initial begin
    rst_n   = 1'b0;
    a_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_a_rvalid", a_rvalid, 0);
    checkOutput("rst_a_outstanding", a_outstanding, 0);
    checkOutput("rst_a_unexp", a_unexp, 0);
    checkOutput("rst_b_rdata", b_rdata, 0);
    checkOutput("rst_c_err", c_err, 0);
    checkOutput("rst_a_d_ready", a_tl_d_ready, 1);
    rst_n = 1'b1;
    step_clock();

    // T1 on b: single read, response two cycles after grant
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
    #1;
    checkOutput("t1_gnt", b_gnt, 1);
    checkOutput("t1_a_valid", b_tl_a_valid, 1);
    checkOutput("t1_opcode_get", b_tl_a_opcode, 4);
    checkOutput("t1_source", b_tl_a_source, 0);
    checkOutput("t1_address", b_tl_a_address, 32'h0000_1000);
    checkOutput("t1_mask", b_tl_a_mask, 4'hF);
    step_clock();
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    #1;
    checkOutput("t1_outstanding", b_outstanding, 1);
    checkOutput("t1_gnt_off", b_gnt, 0);
    step_clock();
    drive_d(1'b1, 8'd0, 32'hA5A5_0001, 1'b0);
    #1;
    checkOutput("t1_no_early_rvalid", b_rvalid, 0);
    step_clock();
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    #1;
    checkOutput("t1_rvalid", b_rvalid, 1);
    checkOutput("t1_rdata", b_rdata, 32'hA5A5_0001);
    checkOutput("t1_err", b_err, 0);
    checkOutput("t1_outstanding_0", b_outstanding, 0);
    step_clock();
    checkOutput("t1_rvalid_pulse", b_rvalid, 0);
    checkOutput("t1_rdata_hold", b_rdata, 32'hA5A5_0001);

    // T4b on b: read-only write completes locally with err
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h0000_3000, 32'h1234_5678);
    #1;
    checkOutput("ro_gnt", b_gnt, 1);
    checkOutput("ro_no_a_valid", b_tl_a_valid, 0);
    step_clock();
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (b_rvalid) begin
        found = 1'b1;
        break;
      end
      step_clock();
    end
    checkOutput("ro_rvalid_seen", found, 1);
    checkOutput("ro_err", b_err, 1);
    checkOutput("ro_rdata", b_rdata, 0);

    // T4 on a: partial write with d_error, then full-write opcode with a_ready low
    do_reset();
    applyStimulus(1'b1, 1'b1, 4'b0011, 32'h0000_2002, 32'hDEAD_BEEF);
    #1;
    checkOutput("pw_a_valid", a_tl_a_valid, 1);
    checkOutput("pw_opcode", a_tl_a_opcode, 1);
    checkOutput("pw_address", a_tl_a_address, 32'h0000_2000);
    checkOutput("pw_mask", a_tl_a_mask, 4'h3);
    checkOutput("pw_data", a_tl_a_data, 32'hDEAD_BEEF);
    checkOutput("pw_size", a_tl_a_size, 2);
    checkOutput("pw_gnt", a_gnt, 1);
    step_clock();
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    drive_d(1'b1, 8'd0, 32'h0, 1'b1);
    #1;
    checkOutput("pw_rvalid_wait", a_rvalid, 0);
    step_clock();
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    #1;
    checkOutput("pw_rvalid", a_rvalid, 1);
    checkOutput("pw_err", a_err, 1);
    a_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h0000_2004, 32'h0);
    #1;
    checkOutput("fw_opcode", a_tl_a_opcode, 0);
    checkOutput("fw_a_valid", a_tl_a_valid, 1);
    checkOutput("fw_gnt_not_ready", a_gnt, 0);
    step_clock();
    a_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    #1;
    checkOutput("fw_outstanding", a_outstanding, 0);

    // T2 on a: four back-to-back reads, fifth held while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h100 + 32'(4 * i), 32'h0);
      #1;
      checkOutput("t2_gnt", a_gnt, 1);
      checkOutput("t2_source", a_tl_a_source, i);
      step_clock();
    end
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h110, 32'h0);
    #1;
    checkOutput("t2_full_gnt", a_gnt, 0);
    checkOutput("t2_full_a_valid", a_tl_a_valid, 0);
    checkOutput("t2_full_outstanding", a_outstanding, 4);

    // T3 on a: responses in source order 2,0,3,1
    drive_d(1'b1, 8'd2, 32'h22, 1'b0);
    step_clock();
    drive_d(1'b1, 8'd0, 32'h00, 1'b0);
    #1;
    checkOutput("t3_held_gnt", a_gnt, 0);
    checkOutput("t3_no_rvalid", a_rvalid, 0);
    step_clock();
    drive_d(1'b1, 8'd3, 32'h33, 1'b0);
    #1;
    checkOutput("t3_rvalid0", a_rvalid, 1);
    checkOutput("t3_rdata0", a_rdata, 32'h00);
    checkOutput("t3_outstanding3", a_outstanding, 3);
    checkOutput("t3_fifth_gnt", a_gnt, 1);
    checkOutput("t3_fifth_source", a_tl_a_source, 0);
    step_clock();
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    drive_d(1'b1, 8'd1, 32'h11, 1'b0);
    #1;
    checkOutput("t3_wait_slot1", a_rvalid, 0);
    checkOutput("t3_outstanding4", a_outstanding, 4);
    step_clock();
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    #1;
    checkOutput("t3_rvalid1", a_rvalid, 1);
    checkOutput("t3_rdata1", a_rdata, 32'h11);
    step_clock();
    checkOutput("t3_rdata2", a_rdata, 32'h22);
    step_clock();
    checkOutput("t3_rdata3", a_rdata, 32'h33);
    checkOutput("t3_outstanding1", a_outstanding, 1);

    // T5 on a: beat for a free source, then reset with two pending
    drive_d(1'b1, 8'd3, 32'h99, 1'b0);
    #1;
    checkOutput("t5_unexp_before", a_unexp, 0);
    step_clock();
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    #1;
    checkOutput("t5_unexp_set", a_unexp, 1);
    checkOutput("t5_ignored_rvalid", a_rvalid, 0);
    checkOutput("t5_outstanding1", a_outstanding, 1);
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
    #1;
    checkOutput("t5_gnt", a_gnt, 1);
    checkOutput("t5_source1", a_tl_a_source, 1);
    step_clock();
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    #1;
    checkOutput("t5_outstanding2", a_outstanding, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_outstanding", a_outstanding, 0);
    checkOutput("t5_rst_unexp", a_unexp, 0);
    step_clock();
    rst_n = 1'b1;
    step_clock();
    drive_d(1'b1, 8'd0, 32'h55, 1'b0);
    step_clock();
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    #1;
    checkOutput("t5_stale_unexp", a_unexp, 1);
    checkOutput("t5_stale_rvalid", a_rvalid, 0);

    // T6 on c: single-outstanding behaviour
    do_reset();
    applyStimulus(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    #1;
    checkOutput("t6_gnt1", c_gnt, 1);
    checkOutput("t6_source", c_tl_a_source, 0);
    step_clock();
    checkOutput("t6_held_gnt", c_gnt, 0);
    checkOutput("t6_outstanding1", c_outstanding, 1);
    step_clock();
    drive_d(1'b1, 8'd0, 32'h77, 1'b0);
    #1;
    checkOutput("t6_held_gnt2", c_gnt, 0);
    step_clock();
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    #1;
    checkOutput("t6_rvalid1", c_rvalid, 1);
    checkOutput("t6_rdata1", c_rdata, 32'h77);
    checkOutput("t6_gnt2", c_gnt, 1);
    checkOutput("t6_source2", c_tl_a_source, 0);
    step_clock();
    applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
    #1;
    checkOutput("t6_outstanding_again", c_outstanding, 1);
    checkOutput("t6_rvalid_pulse", c_rvalid, 0);
    drive_d(1'b1, 8'd0, 32'h88, 1'b0);
    step_clock();
    drive_d(1'b0, 8'd0, 32'h0, 1'b0);
    #1;
    checkOutput("t6_rvalid2", c_rvalid, 1);
    checkOutput("t6_rdata2", c_rdata, 32'h88);
    checkOutput("t6_outstanding0", c_outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
